// File: rtl/system_nios2_gen2_0_cpu_debug_mon_ctrl.sv
// Debug-monitor controller: turns JTAG take_action pulses into single Avalon reads/writes of debug RAM.
// Optional waitrequest timeout via `DEBUG_MON_TIMEOUT_EN (abort after TIMEOUT_CYCLES stalled cycles).
module system_nios2_gen2_0_cpu_debug_mon_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic [9:0]  mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [9:0]  r_mon_areg, w_mon_areg_nxt;
    logic [31:0] r_mon_dreg, w_mon_dreg_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic        r_ready, w_ready_nxt;
    logic        r_error, w_error_nxt;
    logic        w_any_cmd;

    // jdo carries fields for other debug consumers; only some bits matter here.
    logic [5:0]  w_unused_jdo;
    assign w_unused_jdo = {jdo[37:35], jdo[2:0]};

`ifdef DEBUG_MON_TIMEOUT_EN
    logic [15:0] r_tmo_cnt, w_tmo_cnt_nxt;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
`else
    logic [15:0] w_unused_tmo;
    assign w_unused_tmo = 16'(TIMEOUT_CYCLES);
`endif

    assign w_any_cmd = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    always_comb begin
        w_state_nxt    = r_state;
        w_mon_areg_nxt = r_mon_areg;
        w_mon_dreg_nxt = r_mon_dreg;
        w_wdata_nxt    = r_wdata;
        w_ready_nxt    = r_ready;
        w_error_nxt    = r_error;
`ifdef DEBUG_MON_TIMEOUT_EN
        w_tmo_cnt_nxt  = 16'd0;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (take_action_ocimem_a) begin
                    w_mon_areg_nxt = jdo[17:8];
                    w_ready_nxt    = ~jdo[34];
                    w_error_nxt    = 1'b0;
                    w_state_nxt    = jdo[34] ? ST_RD : ST_IDLE;
                end else if (take_action_ocimem_b) begin
                    w_wdata_nxt = jdo[34:3];
                    w_ready_nxt = 1'b0;
                    w_error_nxt = 1'b0;
                    w_state_nxt = ST_WR;
                end else if (take_no_action_ocimem_a) begin
                    w_ready_nxt = 1'b0;
                    w_error_nxt = 1'b0;
                    w_state_nxt = ST_RD;
                end
            end
            ST_RD, ST_WR: begin
                // A busy controller drops new commands but flags the overrun.
                if (w_any_cmd) begin
                    w_error_nxt = 1'b1;
                end
                if (!mem_waitrequest) begin
                    if (r_state == ST_RD) begin
                        w_mon_dreg_nxt = mem_readdata;
                    end
                    w_mon_areg_nxt = r_mon_areg + 10'd1;
                    w_ready_nxt    = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end
`ifdef DEBUG_MON_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_LAST) begin
                    w_error_nxt = 1'b1;
                    w_ready_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_mon_areg <= 10'd0;
            r_mon_dreg <= 32'd0;
            r_wdata    <= 32'd0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
`ifdef DEBUG_MON_TIMEOUT_EN
            r_tmo_cnt  <= 16'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_mon_areg <= w_mon_areg_nxt;
            r_mon_dreg <= w_mon_dreg_nxt;
            r_wdata    <= w_wdata_nxt;
            r_ready    <= w_ready_nxt;
            r_error    <= w_error_nxt;
`ifdef DEBUG_MON_TIMEOUT_EN
            r_tmo_cnt  <= w_tmo_cnt_nxt;
`endif
        end
    end

    // Strobes come straight from state, so command, address and data hold while stalled.
    assign mem_read      = (r_state == ST_RD);
    assign mem_write     = (r_state == ST_WR);
    assign mem_address   = r_mon_areg;
    assign mem_writedata = r_wdata;
    assign MonDReg       = r_mon_dreg;
    assign monitor_ready = r_ready;
    assign monitor_error = r_error;

endmodule

// File: tb/tb_system_nios2_gen2_0_cpu_debug_mon_ctrl.sv
// Directed bench for the debug-monitor controller with a transaction scoreboard.
module tb_system_nios2_gen2_0_cpu_debug_mon_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        act_a, act_b, noact_a;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;
    logic [9:0]  mem_address;
    logic        mem_read, mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        is_wr;
        logic [9:0]  addr;
        logic [31:0] data;
    } txn_t;
    txn_t sb[$];

    logic        rd_pend = 1'b0;
    logic [31:0] rd_exp;

    always #5 clk = ~clk;

    system_nios2_gen2_0_cpu_debug_mon_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .jdo                    (jdo),
        .take_action_ocimem_a   (act_a),
        .take_action_ocimem_b   (act_b),
        .take_no_action_ocimem_a(noact_a),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error),
        .mem_address            (mem_address),
        .mem_read               (mem_read),
        .mem_write              (mem_write),
        .mem_writedata          (mem_writedata),
        .mem_readdata           (mem_readdata),
        .mem_waitrequest        (mem_waitrequest)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] mk_a(input logic [9:0] addr, input logic rd);
        logic [37:0] j;
        j       = '0;
        j[17:8] = addr;
        j[34]   = rd;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        logic [37:0] j;
        j      = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        act_a   = 1'b0;
        act_b   = 1'b0;
        noact_a = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, 32'(mem_address), 32'h0);
        chk({tag, "_dreg"}, MonDReg, 32'h0);
        chk({tag, "_rdy"}, 32'(monitor_ready), 32'h0);
        chk({tag, "_err"}, 32'(monitor_error), 32'h0);
        chk({tag, "_rd"}, 32'(mem_read), 32'h0);
        chk({tag, "_wr"}, 32'(mem_write), 32'h0);
        chk({tag, "_wdat"}, mem_writedata, 32'h0);
    endtask

    // Scoreboard: a completing bus cycle must match the oldest expected transaction.
    always @(negedge clk) begin
        if (rd_pend) begin
            chk("sb_mondreg", MonDReg, rd_exp);
            rd_pend <= 1'b0;
        end
        if (reset_n === 1'b1) begin
            if (mem_read && mem_write) chk("sb_both_strobes", 32'(mem_read & mem_write), 32'h0);
            if ((mem_read || mem_write) && !mem_waitrequest) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_txn", 32'(sb.size()), 32'h1);
                end else begin
                    txn_t t;
                    t = sb.pop_front();
                    chk("sb_kind", 32'(mem_write), 32'(t.is_wr));
                    chk("sb_addr", 32'(mem_address), 32'(t.addr));
                    if (t.is_wr) begin
                        chk("sb_wdata", mem_writedata, t.data);
                    end else begin
                        rd_exp  <= t.data;
                        rd_pend <= 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int hi_cnt;
        reset_n = 1'b0; jdo = '0; clr();
        mem_readdata = 32'h0; mem_waitrequest = 1'b0;
        // Command during reset must be ignored.
        act_a = 1'b1; jdo = mk_a(10'h155, 1'b1);
        step(); step();
        chk_reset_vals("rst");
        clr(); reset_n = 1'b1;
        step();
        chk("post_rst_rd", 32'(mem_read), 32'h0);
        chk("post_rst_addr", 32'(mem_address), 32'h0);

        // Simple read with no stall.
        mem_readdata = 32'hDEADBEEF;
        sb.push_back('{1'b0, 10'h005, 32'hDEADBEEF});
        act_a = 1'b1; jdo = mk_a(10'h005, 1'b1);
        step(); clr();
        chk("rd1_strobe", 32'(mem_read), 32'h1);
        chk("rd1_addr", 32'(mem_address), 32'h005);
        chk("rd1_rdy_low", 32'(monitor_ready), 32'h0);
        step();
        chk("rd1_dreg", MonDReg, 32'hDEADBEEF);
        chk("rd1_rdy", 32'(monitor_ready), 32'h1);
        chk("rd1_rd_drop", 32'(mem_read), 32'h0);
        chk("rd1_inc", 32'(mem_address), 32'h006);

        // Address load only, then a stalled write at the top address that wraps.
        act_a = 1'b1; jdo = mk_a(10'h3FF, 1'b0);
        step(); clr();
        chk("lda_rdy", 32'(monitor_ready), 32'h1);
        chk("lda_addr", 32'(mem_address), 32'h3FF);
        chk("lda_no_rd", 32'(mem_read), 32'h0);
        mem_waitrequest = 1'b1;
        sb.push_back('{1'b1, 10'h3FF, 32'h12345678});
        act_b = 1'b1; jdo = mk_b(32'h12345678);
        step(); clr();
        for (int c = 0; c < 4; c++) begin
            chk("wr_hold_strobe", 32'(mem_write), 32'h1);
            chk("wr_hold_addr", 32'(mem_address), 32'h3FF);
            chk("wr_hold_data", mem_writedata, 32'h12345678);
            if (c == 3) mem_waitrequest = 1'b0;
            if (c < 3) step();
        end
        step();
        chk("wr_drop", 32'(mem_write), 32'h0);
        chk("wr_rdy", 32'(monitor_ready), 32'h1);
        chk("wr_wrap", 32'(mem_address), 32'h000);
        chk("wr_dreg_keep", MonDReg, 32'hDEADBEEF);

        // Overrun during a stalled read.
        mem_waitrequest = 1'b1; mem_readdata = 32'hCAFEF00D;
        sb.push_back('{1'b0, 10'h000, 32'hCAFEF00D});
        noact_a = 1'b1;
        step(); clr();
        chk("ovr_rd", 32'(mem_read), 32'h1);
        chk("ovr_err0", 32'(monitor_error), 32'h0);
        noact_a = 1'b1;
        step(); clr();
        chk("ovr_err1", 32'(monitor_error), 32'h1);
        chk("ovr_rd_held", 32'(mem_read), 32'h1);
        chk("ovr_addr", 32'(mem_address), 32'h000);
        mem_waitrequest = 1'b0;
        step();
        chk("ovr_done", 32'(mem_read), 32'h0);
        chk("ovr_rdy", 32'(monitor_ready), 32'h1);
        chk("ovr_err_sticky", 32'(monitor_error), 32'h1);
        chk("ovr_single_inc", 32'(mem_address), 32'h001);

        // action_a and action_b together: only the load/read happens.
        mem_readdata = 32'h0BADF00D;
        sb.push_back('{1'b0, 10'h020, 32'h0BADF00D});
        act_a = 1'b1; act_b = 1'b1; jdo = mk_a(10'h020, 1'b1);
        step(); clr();
        chk("prio_rd", 32'(mem_read), 32'h1);
        chk("prio_no_wr", 32'(mem_write), 32'h0);
        chk("prio_err_clr", 32'(monitor_error), 32'h0);
        step();
        chk("prio_no_wr2", 32'(mem_write), 32'h0);
        chk("prio_addr", 32'(mem_address), 32'h021);

        // Stuck waitrequest.
        mem_waitrequest = 1'b1; mem_readdata = 32'h55AA55AA;
        noact_a = 1'b1;
        step(); clr();
`ifdef DEBUG_MON_TIMEOUT_EN
        hi_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (mem_read) hi_cnt++;
            step();
        end
        chk("tmo_hi_cycles", 32'(hi_cnt), 32'd4);
        chk("tmo_drop", 32'(mem_read), 32'h0);
        chk("tmo_err", 32'(monitor_error), 32'h1);
        chk("tmo_rdy", 32'(monitor_ready), 32'h1);
        chk("tmo_addr", 32'(mem_address), 32'h021);
        chk("tmo_dreg", MonDReg, 32'h0BADF00D);
        mem_waitrequest = 1'b0;
        sb.push_back('{1'b0, 10'h021, 32'h55AA55AA});
        noact_a = 1'b1;
        step(); clr();
        step();
`else
        hi_cnt = 0;
        for (int c = 0; c < 120; c++) begin
            if (mem_read) hi_cnt++;
            step();
        end
        chk("notmo_hi_cycles", 32'(hi_cnt), 32'd120);
        chk("notmo_rdy", 32'(monitor_ready), 32'h0);
        sb.push_back('{1'b0, 10'h021, 32'h55AA55AA});
        mem_waitrequest = 1'b0;
        step();
`endif
        chk("stuck_exit_addr", 32'(mem_address), 32'h022);
        chk("stuck_exit_dreg", MonDReg, 32'h55AA55AA);

        // Reset pulse during a stalled write.
        mem_waitrequest = 1'b1;
        act_b = 1'b1; jdo = mk_b(32'hA5A55A5A);
        step(); clr();
        chk("rstwr_strobe", 32'(mem_write), 32'h1);
        step();
        reset_n = 1'b0;
        step();
        chk_reset_vals("rstwr");
        reset_n = 1'b1; mem_waitrequest = 1'b0;
        sb.push_back('{1'b1, 10'h000, 32'h11223344});
        act_b = 1'b1; jdo = mk_b(32'h11223344);
        step(); clr();
        chk("after_rst_wr", 32'(mem_write), 32'h1);
        chk("after_rst_wdata", mem_writedata, 32'h11223344);
        step();
        chk("after_rst_rdy", 32'(monitor_ready), 32'h1);
        chk("after_rst_addr", 32'(mem_address), 32'h001);
        chk("after_rst_wr_drop", 32'(mem_write), 32'h0);

        step();
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/system_nios2_gen2_0_cpu_debug_mon_ctrl.md
SYSTEM_NIOS2_GEN2_0_CPU_DEBUG_MON_CTRL -- requirements
Module: system_nios2_gen2_0_cpu_debug_mon_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: waitrequest cycles tolerated before abort (range 1-65535).
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 jdo  in  38  JTAG debug data from the debug-slave sysclk stage.
REQ-005 take_action_ocimem_a  in  1  one-cycle pulse: load address, optional read.
REQ-006 take_action_ocimem_b  in  1  one-cycle pulse: write data at current address.
REQ-007 take_no_action_ocimem_a  in  1  one-cycle pulse: read at current address.
REQ-008 MonDReg  out  32  monitor data register, fed back to the debug slave.
REQ-009 monitor_ready  out  1  last accepted operation completed.
REQ-010 monitor_error  out  1  sticky error: overrun or timeout.
REQ-011 mem_address  out  10  word address to debug RAM.
REQ-012 mem_read / mem_write  out  1 each  Avalon-style strobes, never both high.
REQ-013 mem_writedata  out  32  write data.
REQ-014 mem_readdata  in  32  read data, valid when mem_read high and mem_waitrequest low.
REQ-015 mem_waitrequest  in  1  slave stall; command held stable while high.

Function
REQ-016 FSM states IDLE, RD, WR; IDLE is the only state that accepts commands.
REQ-017 Priority when pulses coincide: take_action_ocimem_a > take_action_ocimem_b > take_no_action_ocimem_a; lower ones dropped silently.
REQ-018 action_a in IDLE: MonAReg <= jdo[17:8]; if jdo[34]=1 go RD, else stay IDLE with monitor_ready=1 next cycle.
REQ-019 action_b in IDLE: mem_writedata <= jdo[34:3], go WR.
REQ-020 no_action_a in IDLE: go RD at MonAReg.
REQ-021 Accepting any command clears monitor_ready and monitor_error the next cycle.
REQ-022 mem_address = MonAReg; strobe asserted the cycle after command acceptance (cycle N+1).
REQ-023 RD completion: first cycle with mem_waitrequest=0; MonDReg <= mem_readdata, mem_read drops, monitor_ready=1 at N+2 minimum.
REQ-024 WR completion: first cycle with mem_waitrequest=0; mem_write drops, monitor_ready=1; MonDReg unchanged.
REQ-025 MonAReg increments by 1 on each successful RD/WR completion; 0x3FF wraps to 0x000.
REQ-026 Command pulse while in RD/WR: dropped, monitor_error <= 1, operation in progress unaffected.
REQ-027 Address, writedata and strobes stable while mem_waitrequest=1.

Reset
REQ-028 reset_n low at a clock edge: state IDLE, MonAReg=0, MonDReg=0, monitor_ready=0, monitor_error=0, mem_read=0, mem_write=0, mem_writedata=0, timeout counter=0.
REQ-029 Reset mid-transaction: strobes low after that edge; no completion, no increment, no MonDReg update.
REQ-030 Command pulses coincident with reset_n low are ignored.

Configuration
REQ-031 Macro DEBUG_MON_TIMEOUT_EN defined: 16-bit counter counts consecutive waitrequest cycles in RD/WR; on reaching TIMEOUT_CYCLES, strobe drops, FSM to IDLE, monitor_error=1, monitor_ready=1, MonAReg and MonDReg unchanged.
REQ-032 Macro undefined: no counter logic, TIMEOUT_CYCLES unused, RD/WR wait indefinitely.

Verification
REQ-033 action_a, jdo[17:8]=0x005, jdo[34]=1, waitrequest=0, readdata=0xDEADBEEF -> mem_read high at N+1 addr 0x005; MonDReg=0xDEADBEEF, monitor_ready=1 at N+2; MonAReg=0x006.
REQ-034 MonAReg=0x3FF, action_b jdo[34:3]=0x12345678, waitrequest high 3 cycles -> mem_write held 4 cycles with addr 0x3FF, data 0x12345678; then ready=1, MonAReg=0x000.
REQ-035 no_action_a during pending read with waitrequest high -> monitor_error=1, read completes normally, single increment.
REQ-036 action_a and action_b same cycle -> only address load/read occurs; no mem_write ever asserted.
REQ-037 DEBUG_MON_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck high -> strobe drops after 4 wait cycles, monitor_error=1, monitor_ready=1, MonAReg unchanged; without macro strobe stays high 100+ cycles.
REQ-038 reset_n low for 1 cycle during WR stall -> all outputs at reset values next cycle; next command accepted normally.
